// File: rtl/precomp_sequencer_if.sv
// rtl/precomp_sequencer_if.sv - link between the precompute sequencer and its n0'/r-t sub-units
interface precomp_sequencer_if #(
    parameter int N_W = 1024,
    parameter int W0  = 32
);
    logic [N_W-1:0] n_sub;
    logic           n0p_start;
    logic           n0p_done;
    logic [W0-1:0]  n0p_in;
    logic           rt_start;
    logic           rt_done;
    logic [N_W-1:0] r_in;
    logic [N_W-1:0] t_in;

    modport master (
        output n_sub, n0p_start, rt_start,
        input  n0p_done, n0p_in, rt_done, r_in, t_in
    );

    modport slave (
        input  n_sub, n0p_start, rt_start,
        output n0p_done, n0p_in, rt_done, r_in, t_in
    );
endinterface

// File: rtl/precomp_sequencer.sv
// rtl/precomp_sequencer.sv - Montgomery precomputation sequencer (n0', r, t) for the RSA core
module precomp_sequencer #(
    parameter int N_W     = 1024,
    parameter int W0      = 32,
    parameter int TIMEOUT = 8192,
    parameter int CNT_W   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_W-1:0]      n,
    output logic                busy,
    output logic                done,
    output logic                valid,
    output logic                error,
    output logic [W0-1:0]       n0p_out,
    output logic [N_W-1:0]      r_out,
    output logic [N_W-1:0]      t_out,
    precomp_sequencer_if.master sub
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam logic [N_W-1:0] N_ONE   = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [N_W-1:0]   n_q;
    logic [CNT_W-1:0] cnt;
    logic             n0p_flag;
    logic             rt_flag;
    logic [W0-1:0]    n0p_hold;
    logic [N_W-1:0]   r_hold;
    logic [N_W-1:0]   t_hold;
    logic             n0p_seen;
    logic             rt_seen;

    assign busy          = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_CAPTURE);
    assign sub.n_sub     = n_q;
    assign sub.n0p_start = (state == S_LAUNCH);
    assign sub.rt_start  = (state == S_LAUNCH);

    // A flag counts as set if it was already set or its done arrives this cycle.
    assign n0p_seen = n0p_flag || sub.n0p_done;
    assign rt_seen  = rt_flag  || sub.rt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_q      <= '0;
            cnt      <= '0;
            n0p_flag <= 1'b0;
            rt_flag  <= 1'b0;
            n0p_hold <= '0;
            r_hold   <= '0;
            t_hold   <= '0;
            done     <= 1'b0;
            valid    <= 1'b0;
            error    <= 1'b0;
            n0p_out  <= '0;
            r_out    <= '0;
            t_out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        n_q      <= n;
                        valid    <= 1'b0;
                        error    <= 1'b0;
                        n0p_flag <= 1'b0;
                        rt_flag  <= 1'b0;
                        cnt      <= '0;
                        if (!n[0] || (n == N_ONE)) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (sub.n0p_done && !n0p_flag) begin
                        n0p_flag <= 1'b1;
                        n0p_hold <= sub.n0p_in;
                    end
                    if (sub.rt_done && !rt_flag) begin
                        rt_flag <= 1'b1;
                        r_hold  <= sub.r_in;
                        t_hold  <= sub.t_in;
                    end
                    // Timeout wins over a done landing in the final budget cycle.
                    if (cnt == CNT_LAST) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else if (n0p_seen && rt_seen) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    n0p_out <= n0p_hold;
                    r_out   <= r_hold;
                    t_out   <= t_hold;
                    done    <= 1'b1;
                    valid   <= 1'b1;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
